// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge used by the write path and the bypass path.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int NUM_BYTES  = DEF_DATA_W / 8;
    localparam int ZERO_REG   = 0;

    // Widest word the merge helper handles; callers zero-extend in and truncate out.
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] merge_bytes(
        input logic [MAX_DATA_W-1:0] oldWord,
        input logic [MAX_DATA_W-1:0] newWord,
        input logic [MAX_BYTES-1:0]  mask
    );
        logic [MAX_DATA_W-1:0] result;
        for (int b = 0; b < MAX_BYTES; b++) begin
            result[8*b +: 8] = mask[b] ? newWord[8*b +: 8] : oldWord[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_2r1w_param_if.sv
// Write/read bus of the 2R1W register file; master drives addresses and write data.
interface regfile_2r1w_param_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [ADDR_W-1:0]   RD;
    logic [ADDR_W-1:0]   RS;
    logic [ADDR_W-1:0]   RT;
    logic [DATA_W-1:0]   dataRD;
    logic                RW;
    logic [DATA_W/8-1:0] ByteEn;
    logic [DATA_W-1:0]   dataRS;
    logic [DATA_W-1:0]   dataRT;

    modport master (
        output RD, RS, RT, dataRD, RW, ByteEn,
        input  dataRS, dataRT
    );

    modport slave (
        input  RD, RS, RT, dataRD, RW, ByteEn,
        output dataRS, dataRT
    );
endinterface

// File: rtl/regfile_read_port.sv
// One read port: zero-register forcing, optional write bypass, optional output register.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic              fwdValid,
    input  logic [DATA_W-1:0] wrMerged,
    input  logic [DATA_W-1:0] storedData,
    output logic [DATA_W-1:0] readData
);
    logic [DATA_W-1:0] combData;
    logic [DATA_W-1:0] dataQ;

    always_comb begin
        combData = storedData;
        if (rdAddr == ADDR_W'(ZERO_REG)) begin
            combData = '0;
        end else if ((BYPASS != 0) && fwdValid && (rdAddr == wrAddr)) begin
            combData = wrMerged;
        end
    end

    // The register captures what the combinational path shows this cycle,
    // so bypass-vs-old-value behaviour carries over to the registered read.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dataQ <= '0;
        end else begin
            dataQ <= combData;
        end
    end

    assign readData = (READ_LAT != 0) ? dataQ : combData;
endmodule

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read/1-write register file with byte-lane writes; register 0 reads zero.
module regfile_2r1w_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_2r1w_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wrMerged;
    logic              wrEnable;
    logic              fwdValid;

    assign wrEnable = bus.RW && (bus.RD != ADDR_W'(ZERO_REG));
    assign fwdValid = wrEnable && !Reset;
    assign wrMerged = DATA_W'(merge_bytes(MAX_DATA_W'(regs[bus.RD]),
                                          MAX_DATA_W'(bus.dataRD),
                                          MAX_BYTES'(bus.ByteEn)));

    // Reset wins over a write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEnable) begin
            regs[bus.RD] <= wrMerged;
        end
    end

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .READ_LAT(READ_LAT)
    ) portS (
        .Clk        (Clk),
        .Reset      (Reset),
        .rdAddr     (bus.RS),
        .wrAddr     (bus.RD),
        .fwdValid   (fwdValid),
        .wrMerged   (wrMerged),
        .storedData (regs[bus.RS]),
        .readData   (bus.dataRS)
    );

    regfile_read_port #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .READ_LAT(READ_LAT)
    ) portT (
        .Clk        (Clk),
        .Reset      (Reset),
        .rdAddr     (bus.RT),
        .wrAddr     (bus.RD),
        .fwdValid   (fwdValid),
        .wrMerged   (wrMerged),
        .storedData (regs[bus.RT]),
        .readData   (bus.dataRT)
    );
endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Drives four register-file configurations (bypass on/off x latency 0/1) with one stimulus stream.
module tb_regfile_2r1w_param;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = DW / 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [AW-1:0] rdV, rsV, rtV;
    logic [DW-1:0] dataV;
    logic          rwV;
    logic [NB-1:0] beV;

    always #5 Clk = ~Clk;

    regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc0 ();
    regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc1 ();
    regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc2 ();
    regfile_2r1w_param_if #(.DATA_W(DW), .ADDR_W(AW)) ifc3 ();

    assign ifc0.RD = rdV; assign ifc0.RS = rsV; assign ifc0.RT = rtV;
    assign ifc0.dataRD = dataV; assign ifc0.RW = rwV; assign ifc0.ByteEn = beV;
    assign ifc1.RD = rdV; assign ifc1.RS = rsV; assign ifc1.RT = rtV;
    assign ifc1.dataRD = dataV; assign ifc1.RW = rwV; assign ifc1.ByteEn = beV;
    assign ifc2.RD = rdV; assign ifc2.RS = rsV; assign ifc2.RT = rtV;
    assign ifc2.dataRD = dataV; assign ifc2.RW = rwV; assign ifc2.ByteEn = beV;
    assign ifc3.RD = rdV; assign ifc3.RS = rsV; assign ifc3.RT = rtV;
    assign ifc3.dataRD = dataV; assign ifc3.RW = rwV; assign ifc3.ByteEn = beV;

    regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .READ_LAT(0))
        u0 (.Clk(Clk), .Reset(Reset), .bus(ifc0));
    regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .READ_LAT(0))
        u1 (.Clk(Clk), .Reset(Reset), .bus(ifc1));
    regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .READ_LAT(1))
        u2 (.Clk(Clk), .Reset(Reset), .bus(ifc2));
    regfile_2r1w_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .READ_LAT(1))
        u3 (.Clk(Clk), .Reset(Reset), .bus(ifc3));

    logic [DW-1:0] outS [4];
    logic [DW-1:0] outT [4];
    assign outS[0] = ifc0.dataRS; assign outT[0] = ifc0.dataRT;
    assign outS[1] = ifc1.dataRS; assign outT[1] = ifc1.dataRT;
    assign outS[2] = ifc2.dataRS; assign outT[2] = ifc2.dataRT;
    assign outS[3] = ifc3.dataRS; assign outT[3] = ifc3.dataRT;

    // Reference model: register contents plus the value each latency-1 port holds.
    logic [DW-1:0] mem  [32];
    logic [DW-1:0] regS [4];
    logic [DW-1:0] regT [4];

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] mergedValue();
        logic [DW-1:0] v;
        v = mem[rdV];
        for (int b = 0; b < NB; b++) begin
            if (beV[b]) v[8*b +: 8] = dataV[8*b +: 8];
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] expComb(input bit byp, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp && rwV && !Reset && rdV != 0 && a == rdV) return mergedValue();
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic rw, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [DW-1:0] data, input logic [NB-1:0] be,
                         input bit doCheck);
        logic [DW-1:0] nS [4];
        logic [DW-1:0] nT [4];
        logic [DW-1:0] newVal;
        bit            doWrite;
        bit            byp;
        Reset = rst; rwV = rw; rdV = rd; rsV = rs; rtV = rt; dataV = data; beV = be;
        #4;
        for (int i = 0; i < 4; i++) begin
            byp = (i == 0) || (i == 2);
            if (doCheck) begin
                check($sformatf("inst%0d_S rs=%0d", i, rs), outS[i], (i >= 2) ? regS[i] : expComb(byp, rs));
                check($sformatf("inst%0d_T rt=%0d", i, rt), outT[i], (i >= 2) ? regT[i] : expComb(byp, rt));
            end
            nS[i] = rst ? '0 : expComb(byp, rs);
            nT[i] = rst ? '0 : expComb(byp, rt);
        end
        doWrite = !rst && rw && rd != 0;
        newVal  = mergedValue();
        @(posedge Clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else if (doWrite) begin
            mem[rd] = newVal;
        end
        regS = nS;
        regT = nT;
        #1;
    endtask

    initial begin
        Reset = 1'b1; rwV = 1'b0; rdV = '0; rsV = '0; rtV = '0; dataV = '0; beV = '0;
        @(posedge Clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 4'h0, 0);

        // Reset state, then basic writes and reads
        cycle(0, 0, 0, 5, 31, 0, 4'h0, 1);
        check("reset_rs5", outS[0], 32'd0);
        cycle(0, 1, 5, 1, 2, 32'd10, 4'hF, 1);
        cycle(0, 1, 6, 5, 1, 32'd5, 4'hF, 1);
        check("read_r5", outS[1], 32'd10);
        cycle(0, 0, 0, 0, 6, 0, 4'h0, 1);
        check("read_r6", outT[1], 32'd5);
        cycle(0, 1, 7, 5, 6, 32'd15, 4'hF, 1);
        cycle(0, 0, 0, 7, 7, 0, 4'h0, 1);
        check("read_r7_S", outS[1], 32'd15);
        check("read_r7_T", outT[1], 32'd15);

        // Register 0 is never written and never forwarded
        cycle(0, 1, 0, 0, 1, 32'd100, 4'hF, 1);
        cycle(0, 0, 0, 2, 0, 0, 4'h0, 1);
        check("r0_zero", outT[0], 32'd0);

        // Byte-lane write
        cycle(0, 1, 9, 0, 0, 32'h11223344, 4'hF, 1);
        cycle(0, 1, 9, 9, 9, 32'hAABBCCDD, 4'b0101, 1);
        cycle(0, 0, 0, 9, 1, 0, 4'h0, 1);
        check("bytelane_r9", outS[1], 32'h11BB33DD);
        cycle(0, 1, 9, 9, 9, 32'h0, 4'h0, 1);

        // Same-cycle bypass to register 3
        cycle(0, 1, 3, 3, 3, 32'd77, 4'hF, 1);
        cycle(0, 0, 0, 3, 0, 0, 4'h0, 1);
        check("after_edge_r3", outS[1], 32'd77);

        // Registered port lag: present 7 once, watch the one-edge delay
        cycle(0, 0, 0, 7, 5, 0, 4'h0, 1);
        check("lat1_r7", outS[2], 32'd15);

        // Reset and write together: write is dropped
        cycle(1, 1, 4, 4, 4, 32'hDEADBEEF, 4'hF, 1);
        cycle(0, 0, 0, 4, 7, 0, 4'h0, 1);
        check("rst_drop_r4", outS[0], 32'd0);
        cycle(0, 0, 0, 4, 5, 0, 4'h0, 1);

        // Randomized traffic with a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 7)),
                  AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)),
                  DW'($urandom),
                  NB'($urandom_range(0, 15)),
                  1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
Parametrised 2-read/1-write general-purpose register file for the CPU datapath, successor to the fixed 32x32 register_file. It adds configurable width and depth, a synchronous clear, byte-lane write enables, optional write-to-read bypass and optional registered read ports for pipelined decode stages. Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 5, address width; depth = 2**ADDR_W registers
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read port; 0 = no forwarding
READ_LAT, 0, read latency in cycles; 0 = combinational read, 1 = registered read

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high; clears all registers and read output registers
RD  input  ADDR_W  write address
RS  input  ADDR_W  read address, port S
RT  input  ADDR_W  read address, port T
dataRD  input  DATA_W  write data
RW  input  1  write enable (1 = write, 0 = read-only cycle)
ByteEn  input  DATA_W/8  per-byte write mask; bit b covers dataRD[8b+7:8b]
dataRS  output  DATA_W  read data for RS
dataRT  output  DATA_W  read data for RT

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high; it acts only on the rising edge.
- Reset: on an edge with Reset=1, all registers are cleared to 0 and the READ_LAT=1 output registers are cleared to 0. Reset has priority: a write presented in the same cycle is dropped. Outputs read 0 from the first edge after Reset is asserted.
- Write: on an edge with Reset=0, RW=1 and RD!=0, each lane b with ByteEn[b]=1 takes dataRD lane b. Lanes with ByteEn[b]=0 keep their value.
- RW=1 with ByteEn all zero writes nothing. RW=1 with RD=0 writes nothing.
- Register 0: always reads 0. It is never forwarded, even when RD=0 and RW=1.
- Merged value M = per lane, ByteEn[b] ? dataRD lane : stored lane of RD.
- READ_LAT=0, BYPASS=0: dataRS = reg[RS], combinational. A write becomes visible in the cycle after its edge.
- READ_LAT=0, BYPASS=1: if RW=1, Reset=0, RD!=0 and RS==RD, then dataRS = M in the same cycle; otherwise dataRS = reg[RS].
- READ_LAT=1: dataRS is registered. On each edge it loads the value the READ_LAT=0 path would produce for the current RS, so the result appears one cycle after the address is presented. With BYPASS=1, reading the address being written in that cycle returns M. With BYPASS=0 it returns the pre-write value.
- Port T behaves identically to port S. RS==RT is legal, and both ports return the same value.
- Address width is exact; there is no out-of-range case. X or Z on RW or Reset is a verification error, not a defined mode.

Decomposition:
- Shared package regfile_pkg:
  - function merge_bytes(old, new, mask), used by both the write path and the bypass path
  - localparam NUM_BYTES = DATA_W/8
  - constant ZERO_REG = 0
- One natural sub-module, regfile_read_port. Instantiated twice, it holds the address compare, bypass mux, zero-register forcing and the optional output register (generate on READ_LAT).
- The storage array and write logic stay in the top level.

Test Plan:
- Reset held 1 cycle, then read RS=5, RT=31 -> dataRS=0, dataRT=0.
- Write 10 to reg 5 (ByteEn=4'hF), then RS=5 -> dataRS=10. Write 5 to reg 6, then RT=6 -> dataRT=5. Write dataRS+dataRT to reg 7, then RS=RT=7 -> both read 15.
- Write 100 to reg 0 with RW=1, then RT=0 -> dataRT=0. With RS=0 in the write cycle and BYPASS=1 -> dataRS=0.
- Reg 9 = 32'h11223344, then write 32'hAABBCCDD with ByteEn=4'b0101 -> reg 9 reads 32'h11BB33DD.
- BYPASS=1, READ_LAT=0: RW=1, RD=RS=3, dataRD=77 -> dataRS=77 in the same cycle. With BYPASS=0 -> old value, then 77 after the edge.
- READ_LAT=1: present RS=7 -> dataRS updates exactly one edge later. Reset and a write to reg 4 in the same cycle -> reg 4 reads 0 afterwards.
